// File: rtl/fft_peak_picker.sv
// Streaming peak picker for FFT source output: computes per-bin power, tracks the
// strongest bin inside [MIN_BIN, MAX_BIN] and reports it (or a frame error) at end of frame.
module fft_peak_picker #(
    parameter int DATA_W  = 16,
    parameter int FFT_PTS = 1024,
    parameter int BIN_W   = 10,
    parameter int MIN_BIN = 1,
    parameter int MAX_BIN = 511
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  src_valid,
    input  logic                  src_sop,
    input  logic                  src_eop,
    input  logic [1:0]            src_error,
    input  logic [DATA_W-1:0]     src_real,
    input  logic [DATA_W-1:0]     src_imag,
    output logic                  src_ready,
    input  logic [2*DATA_W-1:0]   threshold,
    output logic                  peak_valid,
    output logic                  peak_found,
    output logic [BIN_W-1:0]      peak_bin,
    output logic [2*DATA_W-1:0]   peak_power,
    output logic                  frame_err
);

    localparam int PW = 2 * DATA_W;
    localparam logic [BIN_W-1:0] LAST_BIN  = BIN_W'(FFT_PTS - 1);
    localparam logic [BIN_W-1:0] MIN_BIN_L = BIN_W'(MIN_BIN);
    localparam logic [BIN_W-1:0] MAX_BIN_L = BIN_W'(MAX_BIN);

    typedef enum logic {
        IDLE,
        FRAME
    } state_t;

    typedef struct packed {
        logic             v;
        logic             clr;
        logic             done;
        logic             err;
        logic [BIN_W-1:0] bin;
        logic [PW-1:0]    thr;
    } tag_t;

    state_t            state_q, state_d;
    logic [BIN_W-1:0]  next_bin_q, next_bin_d;
    logic              bad_q, bad_d;
    logic              src_ready_q, src_ready_d;

    tag_t              tag_d, s0_tag_q, s1_tag_q, s2_tag_q;
    logic [DATA_W-1:0] s0_re_q, s0_re_d, s0_im_q, s0_im_d;
    logic [PW-1:0]     s1_sq_re_q, s1_sq_re_d, s1_sq_im_q, s1_sq_im_d;
    logic [PW-1:0]     s2_pow_q, s2_pow_d;

    logic [PW-1:0]     max_pow_q, max_pow_d;
    logic [BIN_W-1:0]  max_bin_q, max_bin_d;
    logic              peak_valid_q, peak_valid_d;
    logic              peak_found_q, peak_found_d;
    logic [BIN_W-1:0]  peak_bin_q, peak_bin_d;
    logic [PW-1:0]     peak_power_q, peak_power_d;
    logic              frame_err_q, frame_err_d;

    logic              accept;
    logic              bad_now;
    logic signed [PW-1:0] re_ext, im_ext;
    logic [PW-1:0]     cur_pow;
    logic [BIN_W-1:0]  cur_bin;
    logic              in_win;

    assign accept = src_valid && src_ready_q;

    // Frame framing FSM: decides each beat's bin index and whether it ends the frame cleanly.
    always_comb begin
        state_d     = state_q;
        next_bin_d  = next_bin_q;
        bad_d       = bad_q;
        src_ready_d = 1'b1;
        tag_d       = '0;
        tag_d.bin   = next_bin_q;
        tag_d.thr   = threshold;
        bad_now     = bad_q || (src_error != 2'b00);
        if (accept) begin
            if (src_sop) begin
                tag_d.err = (state_q == FRAME);
                tag_d.v   = 1'b1;
                tag_d.clr = 1'b1;
                tag_d.bin = '0;
                bad_now   = (src_error != 2'b00);
            end else if (state_q == FRAME) begin
                tag_d.v = 1'b1;
            end
            if (tag_d.v) begin
                state_d    = FRAME;
                next_bin_d = tag_d.bin + BIN_W'(1);
                bad_d      = bad_now;
                if (src_eop) begin
                    state_d = IDLE;
                    if (tag_d.bin == LAST_BIN && !bad_now) begin
                        tag_d.done = 1'b1;
                    end else begin
                        tag_d.err = 1'b1;
                    end
                end else if (tag_d.bin == LAST_BIN) begin
                    state_d   = IDLE;
                    tag_d.err = 1'b1;
                end
            end
        end
    end

    always_comb begin
        s0_re_d    = src_real;
        s0_im_d    = src_imag;
        re_ext     = {{DATA_W{s0_re_q[DATA_W-1]}}, s0_re_q};
        im_ext     = {{DATA_W{s0_im_q[DATA_W-1]}}, s0_im_q};
        s1_sq_re_d = re_ext * re_ext;
        s1_sq_im_d = im_ext * im_ext;
        s2_pow_d   = s1_sq_re_q + s1_sq_im_q;
    end

    // Running max restarts on the sop beat; strict compare keeps the lowest bin on ties.
    always_comb begin
        cur_pow      = s2_tag_q.clr ? '0 : max_pow_q;
        cur_bin      = s2_tag_q.clr ? MIN_BIN_L : max_bin_q;
        in_win       = (s2_tag_q.bin >= MIN_BIN_L) && (s2_tag_q.bin <= MAX_BIN_L);
        max_pow_d    = max_pow_q;
        max_bin_d    = max_bin_q;
        peak_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        peak_found_d = peak_found_q;
        peak_bin_d   = peak_bin_q;
        peak_power_d = peak_power_q;
        if (s2_tag_q.v) begin
            max_pow_d = cur_pow;
            max_bin_d = cur_bin;
            if (in_win && (s2_pow_q > cur_pow)) begin
                max_pow_d = s2_pow_q;
                max_bin_d = s2_tag_q.bin;
            end
            frame_err_d = s2_tag_q.err;
            if (s2_tag_q.done) begin
                peak_valid_d = 1'b1;
                peak_bin_d   = max_bin_d;
                peak_power_d = max_pow_d;
                peak_found_d = (max_pow_d >= s2_tag_q.thr);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            next_bin_q   <= '0;
            bad_q        <= 1'b0;
            src_ready_q  <= 1'b0;
            s0_tag_q     <= '0;
            s1_tag_q     <= '0;
            s2_tag_q     <= '0;
            s0_re_q      <= '0;
            s0_im_q      <= '0;
            s1_sq_re_q   <= '0;
            s1_sq_im_q   <= '0;
            s2_pow_q     <= '0;
            max_pow_q    <= '0;
            max_bin_q    <= '0;
            peak_valid_q <= 1'b0;
            peak_found_q <= 1'b0;
            peak_bin_q   <= '0;
            peak_power_q <= '0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            next_bin_q   <= next_bin_d;
            bad_q        <= bad_d;
            src_ready_q  <= src_ready_d;
            s0_tag_q     <= tag_d;
            s1_tag_q     <= s0_tag_q;
            s2_tag_q     <= s1_tag_q;
            s0_re_q      <= s0_re_d;
            s0_im_q      <= s0_im_d;
            s1_sq_re_q   <= s1_sq_re_d;
            s1_sq_im_q   <= s1_sq_im_d;
            s2_pow_q     <= s2_pow_d;
            max_pow_q    <= max_pow_d;
            max_bin_q    <= max_bin_d;
            peak_valid_q <= peak_valid_d;
            peak_found_q <= peak_found_d;
            peak_bin_q   <= peak_bin_d;
            peak_power_q <= peak_power_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign src_ready  = src_ready_q;
    assign peak_valid = peak_valid_q;
    assign peak_found = peak_found_q;
    assign peak_bin   = peak_bin_q;
    assign peak_power = peak_power_q;
    assign frame_err  = frame_err_q;

endmodule
